flt_pds2_rr_scheduler: RTL and testbench
========================================

// Module: flt_pds2_rr_scheduler
// PURPOSE
//  Shares one fixed-latency flt_pds2 float core (no backpressure) among NUM_REQ requesters.
//  Round-robin arbitration over AXI4-Stream inputs; a tag pipeline matched to core latency
//  routes each result back to its issuer. Drain FSM quiesces the core before reconfig or power-down.
// PARAMETERS
//  NUM_REQ          4   number of requesters, 2..16
//  TDATA_WIDTH      32  operand width, equal to core i_axi4s_a_tdata
//  TDATA_OUT_WIDTH  32  result width, equal to core o_axi4s_result_tdata
//  PIPE_STAGE_NUM   14  core latency in cycles, from core tvalid in to result tvalid
//  Derived: TAG_W=$clog2(NUM_REQ), CNT_W=$clog2(PIPE_STAGE_NUM+2)
// PORTS
//  i_aclk                 in   1                   clock
//  i_areset               in   1                   async reset, active-high
//  i_req_tdata            in   NUM_REQ*TDATA_WIDTH requester operands, req k at [k*W+:W]
//  i_req_tvalid           in   NUM_REQ             requester valid
//  o_req_tready           out  NUM_REQ             requester ready, at most one bit set (one-hot)
//  o_axi4s_a_tdata        out  TDATA_WIDTH         operand to core
//  o_axi4s_a_tvalid       out  1                   operand valid to core
//  i_axi4s_result_tdata   in   TDATA_OUT_WIDTH     core result
//  i_axi4s_result_tvalid  in   1                   core result valid
//  o_rsp_tdata            out  TDATA_OUT_WIDTH     result broadcast to all requesters
//  o_rsp_tvalid           out  NUM_REQ             one-hot result valid, no backpressure
//  i_drain                in   1                   level request: stop issuing and empty the core
//  o_drained              out  1                   core empty and scheduler in DRAINED
//  o_inflight             out  CNT_W               operations issued but not yet returned
//  o_err                  out  1                   sticky: result arrived with no valid tag
// BEHAVIOUR
//  Reset: all outputs 0; FSM=RUN; RR pointer=NUM_REQ-1, so req0 has first priority.
//   Tag pipeline and counter clear. Reset mid-operation drops in-flight results.
//   Results arriving after reset release are flagged by o_err.
//  Arbitration (combinational): in RUN with i_drain=0, grant the first k with i_req_tvalid[k]=1,
//   searching ptr+1, ptr+2, ... with wrap mod NUM_REQ. o_req_tready[k]=1 for that k only.
//   On handshake, ptr<=k. No grant when no requester is valid; ptr holds.
//  Issue: handshake registers tdata into o_axi4s_a_tdata, with o_axi4s_a_tvalid=1 on the next cycle.
//   Throughput: 1 op/cycle. Total latency req handshake -> o_rsp_tvalid = PIPE_STAGE_NUM+2.
//  Tag pipe: PIPE_STAGE_NUM stages of {valid, TAG_W}, loaded with {o_axi4s_a_tvalid, tag} at issue.
//   Its head is aligned with i_axi4s_result_tvalid.
//  Return: when result_tvalid and head.valid=1, register tdata into o_rsp_tdata.
//   Next cycle, o_rsp_tvalid[head.tag]=1 for one cycle.
//   When result_tvalid=1 and head.valid=0, set o_err, suppress the response, leave o_inflight unchanged.
//   A head.valid=1 with result_tvalid=0 is a lost result: set o_err and decrement o_inflight.
//  o_inflight: +1 on each core issue, -1 on each tag-pipe head retire.
//   Simultaneous +1/-1 leaves it unchanged. It never wraps; max is PIPE_STAGE_NUM+1.
//  FSM: RUN --i_drain=1--> DRAIN.
//   DRAIN --o_inflight==0 and o_axi4s_a_tvalid==0--> DRAINED.
//   DRAINED --i_drain=0--> RUN.
//   DRAIN --i_drain=0--> RUN, without waiting for the core to empty.
//   o_req_tready is 0 whenever i_drain=1 or FSM!=RUN.
//   An op registered in the same cycle i_drain rises still issues and is counted.
//   o_drained=1 only in DRAINED. It drops the cycle after i_drain falls.
// CONFIGURATION
//  FLT_SCHED_PERF_CNT_EN defined: adds output o_issue_cnt [NUM_REQ*32].
//   It holds per-requester 32-bit issue counters that wrap at 2^32 and clear on i_areset.
//   Counter k increments on each handshake of req k.
//  Undefined: the port and counters are absent, and all other behaviour is identical.
// TESTING
//  Reset, then req1 alone sends 0x3F800000 (1.0) -> o_req_tready=4'b0010.
//   Core tvalid 1 cycle later; o_rsp_tvalid=4'b0010 16 cycles after handshake; o_inflight returns to 0.
//  All 4 requesters hold tvalid for 8 cycles -> grants 0,1,2,3,0,1,2,3.
//   Responses in the same order, one per cycle; o_inflight peaks at 8 with no gaps.
//  Requesters 0 and 2 valid, 1 and 3 idle, ptr=0 -> grants 2,0,2,0; ptr wraps 3->0 correctly.
//  Stream 10 ops, raise i_drain on cycle 5 -> ready drops that cycle; in-flight results still return.
//   o_drained=1 once o_inflight=0; deassert i_drain -> RUN on the next cycle, grants resume.
//  Inject i_axi4s_result_tvalid with empty tag pipe -> o_err=1, o_rsp_tvalid=0, o_inflight=0.
//   o_err holds until i_areset.
//  Assert i_areset with 5 ops in flight -> all outputs 0 immediately.
//   Late core results after release set o_err. With FLT_SCHED_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/flt_pds2_rr_scheduler_if.sv
// Requester and core-facing streams of the flt_pds2 round-robin scheduler.
// slave = scheduler side, master = requesters plus the core.
interface flt_pds2_rr_scheduler_if #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned TDATA_WIDTH     = 32,
  parameter int unsigned TDATA_OUT_WIDTH = 32
);
  logic [NUM_REQ*TDATA_WIDTH-1:0] i_req_tdata;
  logic [NUM_REQ-1:0]             i_req_tvalid;
  logic [NUM_REQ-1:0]             o_req_tready;
  logic [TDATA_WIDTH-1:0]         o_axi4s_a_tdata;
  logic                           o_axi4s_a_tvalid;
  logic [TDATA_OUT_WIDTH-1:0]     i_axi4s_result_tdata;
  logic                           i_axi4s_result_tvalid;
  logic [TDATA_OUT_WIDTH-1:0]     o_rsp_tdata;
  logic [NUM_REQ-1:0]             o_rsp_tvalid;

  modport slave (
    input  i_req_tdata, i_req_tvalid, i_axi4s_result_tdata, i_axi4s_result_tvalid,
    output o_req_tready, o_axi4s_a_tdata, o_axi4s_a_tvalid, o_rsp_tdata, o_rsp_tvalid
  );

  modport master (
    output i_req_tdata, i_req_tvalid, i_axi4s_result_tdata, i_axi4s_result_tvalid,
    input  o_req_tready, o_axi4s_a_tdata, o_axi4s_a_tvalid, o_rsp_tdata, o_rsp_tvalid
  );
endinterface

// File: rtl/flt_pds2_rr_scheduler.sv
// Round-robin sharing of one fixed-latency flt_pds2 core with tag-routed results and a drain FSM.
// Optional per-requester issue counters: define FLT_SCHED_PERF_CNT_EN.
module flt_pds2_rr_scheduler #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned TDATA_WIDTH     = 32,
  parameter int unsigned TDATA_OUT_WIDTH = 32,
  parameter int unsigned PIPE_STAGE_NUM  = 14,
  localparam int unsigned TAG_W          = $clog2(NUM_REQ),
  localparam int unsigned CNT_W          = $clog2(PIPE_STAGE_NUM + 2)
) (
  input  logic                        i_aclk,
  input  logic                        i_areset,
  flt_pds2_rr_scheduler_if.slave      bus,
  input  logic                        i_drain,
  output logic                        o_drained,
  output logic [CNT_W-1:0]            o_inflight,
  output logic                        o_err
`ifdef FLT_SCHED_PERF_CNT_EN
  ,
  output logic [NUM_REQ*32-1:0]       o_issue_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DRAINED = 2'd2
  } state_e;

  state_e                                  state_q, state_d;
  logic [TAG_W-1:0]                        ptr_q;
  logic                                    a_tvalid_q;
  logic [TDATA_WIDTH-1:0]                  a_tdata_q;
  logic [TAG_W-1:0]                        a_tag_q;
  logic [PIPE_STAGE_NUM-1:0]               pipe_vld_q;
  logic [PIPE_STAGE_NUM-1:0][TAG_W-1:0]    pipe_tag_q;
  logic [TDATA_OUT_WIDTH-1:0]              rsp_tdata_q;
  logic [NUM_REQ-1:0]                      rsp_vld_q, rsp_vld_d;
  logic [CNT_W-1:0]                        inflight_q;
  logic                                    err_q;

  logic [TAG_W-1:0]                        cand_c;
  logic [TAG_W-1:0]                        grant_idx_c;
  logic                                    grant_vld_c;
  logic [NUM_REQ-1:0]                      grant_c;
  logic                                    head_vld_c;
  logic [TAG_W-1:0]                        head_tag_c;

  assign head_vld_c = pipe_vld_q[PIPE_STAGE_NUM-1];
  assign head_tag_c = pipe_tag_q[PIPE_STAGE_NUM-1];

  // Round-robin search starting just after the last granted requester
  always_comb begin
    cand_c      = '0;
    grant_idx_c = '0;
    grant_vld_c = 1'b0;
    grant_c     = '0;
    if (state_q == ST_RUN && !i_drain && !i_areset) begin
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
        cand_c = TAG_W'((32'(ptr_q) + i) % NUM_REQ);
        if (!grant_vld_c && bus.i_req_tvalid[cand_c]) begin
          grant_vld_c = 1'b1;
          grant_idx_c = cand_c;
        end
      end
    end
    grant_c[grant_idx_c] = grant_vld_c;
  end

  always_comb begin
    rsp_vld_d = '0;
    if (bus.i_axi4s_result_tvalid && head_vld_c) begin
      rsp_vld_d[head_tag_c] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:     if (i_drain) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!i_drain) begin
          state_d = ST_RUN;
        end else if (inflight_q == '0 && !a_tvalid_q) begin
          state_d = ST_DRAINED;
        end
      end
      ST_DRAINED: if (!i_drain) state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Issue register, tag pipe aligned to core latency, and result return
  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      ptr_q       <= TAG_W'(NUM_REQ - 1);
      a_tvalid_q  <= 1'b0;
      a_tdata_q   <= '0;
      a_tag_q     <= '0;
      pipe_vld_q  <= '0;
      pipe_tag_q  <= '0;
      rsp_tdata_q <= '0;
      rsp_vld_q   <= '0;
      inflight_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      a_tvalid_q <= grant_vld_c;
      if (grant_vld_c) begin
        ptr_q     <= grant_idx_c;
        a_tag_q   <= grant_idx_c;
        a_tdata_q <= bus.i_req_tdata[32'(grant_idx_c)*TDATA_WIDTH +: TDATA_WIDTH];
      end
      pipe_vld_q[0] <= a_tvalid_q;
      pipe_tag_q[0] <= a_tag_q;
      for (int unsigned s = 1; s < PIPE_STAGE_NUM; s++) begin
        pipe_vld_q[s] <= pipe_vld_q[s-1];
        pipe_tag_q[s] <= pipe_tag_q[s-1];
      end
      rsp_vld_q <= rsp_vld_d;
      if (bus.i_axi4s_result_tvalid && head_vld_c) begin
        rsp_tdata_q <= bus.i_axi4s_result_tdata;
      end
      if (bus.i_axi4s_result_tvalid != head_vld_c) begin
        err_q <= 1'b1;
      end
      if (grant_vld_c && !head_vld_c) begin
        inflight_q <= inflight_q + CNT_W'(1);
      end else if (!grant_vld_c && head_vld_c) begin
        inflight_q <= inflight_q - CNT_W'(1);
      end
    end
  end

`ifdef FLT_SCHED_PERF_CNT_EN
  logic [NUM_REQ-1:0][31:0] issue_cnt_q;

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      issue_cnt_q <= '0;
    end else if (grant_vld_c) begin
      issue_cnt_q[grant_idx_c] <= issue_cnt_q[grant_idx_c] + 32'd1;
    end
  end

  assign o_issue_cnt = issue_cnt_q;
`endif

  assign bus.o_req_tready     = grant_c;
  assign bus.o_axi4s_a_tdata  = a_tdata_q;
  assign bus.o_axi4s_a_tvalid = a_tvalid_q;
  assign bus.o_rsp_tdata      = rsp_tdata_q;
  assign bus.o_rsp_tvalid     = rsp_vld_q;
  assign o_drained            = (state_q == ST_DRAINED);
  assign o_inflight           = inflight_q;
  assign o_err                = err_q;

endmodule

// File: tb/tb_flt_pds2_rr_scheduler.sv
// Directed bench for flt_pds2_rr_scheduler with a 14-cycle negate-sign core model.
module tb_flt_pds2_rr_scheduler;
  localparam int unsigned NR = 4;
  localparam int unsigned W  = 32;
  localparam int unsigned PS = 14;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       drain = 1'b0;
  logic       drained;
  logic       err;
  logic [3:0] infl;
  logic       inj_v = 1'b0;
  logic [W-1:0] inj_d = '0;
`ifdef FLT_SCHED_PERF_CNT_EN
  logic [NR*32-1:0] issue_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  flt_pds2_rr_scheduler_if #(.NUM_REQ(NR), .TDATA_WIDTH(W), .TDATA_OUT_WIDTH(W)) bus ();

  flt_pds2_rr_scheduler #(
    .NUM_REQ(NR), .TDATA_WIDTH(W), .TDATA_OUT_WIDTH(W), .PIPE_STAGE_NUM(PS)
  ) dut (
    .i_aclk(clk),
    .i_areset(rst),
    .bus(bus),
    .i_drain(drain),
    .o_drained(drained),
    .o_inflight(infl),
    .o_err(err)
`ifdef FLT_SCHED_PERF_CNT_EN
    ,
    .o_issue_cnt(issue_cnt)
`endif
  );

  // Core model: fixed latency, result is the operand with its sign flipped, never reset
  logic [PS-1:0] cm_v = '0;
  logic [W-1:0]  cm_d [PS];

  always @(posedge clk) begin
    cm_v <= {cm_v[PS-2:0], bus.o_axi4s_a_tvalid};
    cm_d[0] <= bus.o_axi4s_a_tdata ^ 32'h8000_0000;
    for (int s = PS - 1; s > 0; s--) cm_d[s] <= cm_d[s-1];
  end

  assign bus.i_axi4s_result_tvalid = cm_v[PS-1] | inj_v;
  assign bus.i_axi4s_result_tdata  = inj_v ? inj_d : cm_d[PS-1];

  int         log_cyc [$];
  logic [3:0] log_v [$];
  logic [W-1:0] log_d [$];

  always @(negedge clk) begin
    if (bus.o_rsp_tvalid != '0) begin
      log_cyc.push_back(cyc);
      log_v.push_back(bus.o_rsp_tvalid);
      log_d.push_back(bus.o_rsp_tdata);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_cyc.delete();
    log_v.delete();
    log_d.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_req_tvalid = '0;
    drain = 1'b0;
    inj_v = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.i_req_tvalid = '0;
    bus.i_req_tdata = '0;
    step();
    tests_run++; if (bus.o_axi4s_a_tvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_a_tvalid: got %b want 0", bus.o_axi4s_a_tvalid); end
    tests_run++; if (bus.o_rsp_tvalid !== 4'b0000) begin tests_failed++; $display("FAIL reset_rsp_tvalid: got %b want 0000", bus.o_rsp_tvalid); end
    tests_run++; if (infl !== 4'd0) begin tests_failed++; $display("FAIL reset_inflight: got %0d want 0", infl); end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b want 0", err); end
    tests_run++; if (drained !== 1'b0) begin tests_failed++; $display("FAIL reset_drained: got %b want 0", drained); end
    rst = 1'b0;
    step();
    tests_run++; if (bus.o_req_tready !== 4'b0000) begin tests_failed++; $display("FAIL reset_tready_idle: got %b want 0000", bus.o_req_tready); end
  endtask

  task automatic test_single();
    int k;
    clear_log();
    bus.i_req_tdata[1*W +: W] = 32'h3F80_0000;
    bus.i_req_tvalid = 4'b0010;
    #1;
    tests_run++; if (bus.o_req_tready !== 4'b0010) begin tests_failed++; $display("FAIL single_grant: got %b want 0010", bus.o_req_tready); end
    step();
    bus.i_req_tvalid = '0;
    tests_run++; if (bus.o_axi4s_a_tvalid !== 1'b1 || bus.o_axi4s_a_tdata !== 32'h3F80_0000) begin tests_failed++; $display("FAIL single_issue: got v=%b d=%h want v=1 d=3f800000", bus.o_axi4s_a_tvalid, bus.o_axi4s_a_tdata); end
    tests_run++; if (infl !== 4'd1) begin tests_failed++; $display("FAIL single_inflight_up: got %0d want 1", infl); end
    k = 0;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (bus.o_rsp_tvalid != '0) begin k = n; break; end
    end
    tests_run++; if (k != 15) begin tests_failed++; $display("FAIL single_latency: rsp seen %0d cycles after edge following handshake, want 15", k); end
    tests_run++; if (bus.o_rsp_tvalid !== 4'b0010 || bus.o_rsp_tdata !== 32'hBF80_0000) begin tests_failed++; $display("FAIL single_rsp: got v=%b d=%h want v=0010 d=bf800000", bus.o_rsp_tvalid, bus.o_rsp_tdata); end
    tests_run++; if (infl !== 4'd0) begin tests_failed++; $display("FAIL single_inflight_down: got %0d want 0", infl); end
    step();
    tests_run++; if (bus.o_rsp_tvalid !== 4'b0000) begin tests_failed++; $display("FAIL single_rsp_pulse: got %b want 0000", bus.o_rsp_tvalid); end
    repeat (4) step();
  endtask

  task automatic test_all4();
    do_reset();
    clear_log();
    for (int i = 0; i < 8; i++) begin
      for (int r = 0; r < 4; r++) bus.i_req_tdata[r*W +: W] = 32'(i * 16 + r);
      bus.i_req_tvalid = 4'b1111;
      #1;
      tests_run++; if (bus.o_req_tready !== 4'(1 << (i % 4))) begin tests_failed++; $display("FAIL all4_grant%0d: got %b want %b", i, bus.o_req_tready, 4'(1 << (i % 4))); end
      step();
      tests_run++; if (bus.o_axi4s_a_tdata !== 32'(i * 16 + i % 4)) begin tests_failed++; $display("FAIL all4_issue%0d: got %h want %h", i, bus.o_axi4s_a_tdata, 32'(i * 16 + i % 4)); end
    end
    bus.i_req_tvalid = '0;
    tests_run++; if (infl !== 4'd8) begin tests_failed++; $display("FAIL all4_inflight_peak: got %0d want 8", infl); end
    for (int n = 0; n < 30 && log_v.size() < 8; n++) step();
    tests_run++; if (log_v.size() != 8) begin tests_failed++; $display("FAIL all4_rsp_count: got %0d want 8", log_v.size()); end
    for (int j = 0; j < 8 && j < log_v.size(); j++) begin
      tests_run++;
      if (log_v[j] !== 4'(1 << (j % 4)) || log_d[j] !== (32'(j * 16 + j % 4) ^ 32'h8000_0000) || log_cyc[j] != log_cyc[0] + j) begin
        tests_failed++;
        $display("FAIL all4_rsp%0d: got v=%b d=%h cyc+%0d want v=%b d=%h cyc+%0d", j, log_v[j], log_d[j],
                 log_cyc[j] - log_cyc[0], 4'(1 << (j % 4)), 32'(j * 16 + j % 4) ^ 32'h8000_0000, j);
      end
    end
    step();
    tests_run++; if (infl !== 4'd0) begin tests_failed++; $display("FAIL all4_inflight_end: got %0d want 0", infl); end
  endtask

  task automatic test_two_sparse();
    logic [3:0] exp_g [4];
    exp_g[0] = 4'b0100; exp_g[1] = 4'b0001; exp_g[2] = 4'b0100; exp_g[3] = 4'b0001;
    do_reset();
    bus.i_req_tvalid = 4'b0001;
    #1;
    tests_run++; if (bus.o_req_tready !== 4'b0001) begin tests_failed++; $display("FAIL sparse_setup: got %b want 0001", bus.o_req_tready); end
    step();
    bus.i_req_tvalid = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++; if (bus.o_req_tready !== exp_g[i]) begin tests_failed++; $display("FAIL sparse_grant%0d: got %b want %b", i, bus.o_req_tready, exp_g[i]); end
      step();
    end
    bus.i_req_tvalid = '0;
    repeat (25) step();
  endtask

  task automatic test_drain();
    bit seen;
    do_reset();
    clear_log();
    bus.i_req_tvalid = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      bus.i_req_tdata[3*W +: W] = 32'h100 + 32'(c);
      #1;
      tests_run++; if (bus.o_req_tready !== 4'b1000) begin tests_failed++; $display("FAIL drain_pre_grant%0d: got %b want 1000", c, bus.o_req_tready); end
      step();
    end
    drain = 1'b1;
    #1;
    tests_run++; if (bus.o_req_tready !== 4'b0000) begin tests_failed++; $display("FAIL drain_ready_drop: got %b want 0000", bus.o_req_tready); end
    step();
    tests_run++; if (drained !== 1'b0 || infl !== 4'd5) begin tests_failed++; $display("FAIL drain_busy: got drained=%b infl=%0d want 0/5", drained, infl); end
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (drained) begin seen = 1'b1; break; end
    end
    tests_run++; if (!seen || infl !== 4'd0 || log_v.size() != 5) begin tests_failed++; $display("FAIL drain_done: got drained=%b infl=%0d rsps=%0d want 1/0/5", seen, infl, log_v.size()); end
    drain = 1'b0;
    #1;
    tests_run++; if (drained !== 1'b1 || bus.o_req_tready !== 4'b0000) begin tests_failed++; $display("FAIL drain_release_same: got drained=%b ready=%b want 1/0000", drained, bus.o_req_tready); end
    step();
    tests_run++; if (drained !== 1'b0 || bus.o_req_tready !== 4'b1000) begin tests_failed++; $display("FAIL drain_resume: got drained=%b ready=%b want 0/1000", drained, bus.o_req_tready); end
    for (int c = 5; c < 10; c++) begin
      bus.i_req_tdata[3*W +: W] = 32'h100 + 32'(c);
      step();
    end
    bus.i_req_tvalid = '0;
    for (int n = 0; n < 30 && log_v.size() < 10; n++) step();
    tests_run++; if (log_v.size() != 10) begin tests_failed++; $display("FAIL drain_total_rsp: got %0d want 10", log_v.size()); end
    for (int j = 0; j < 10 && j < log_v.size(); j++) begin
      tests_run++;
      if (log_v[j] !== 4'b1000 || log_d[j] !== ((32'h100 + 32'(j)) ^ 32'h8000_0000)) begin
        tests_failed++;
        $display("FAIL drain_rsp%0d: got v=%b d=%h want v=1000 d=%h", j, log_v[j], log_d[j], (32'h100 + 32'(j)) ^ 32'h8000_0000);
      end
    end
    repeat (3) step();
  endtask

  task automatic test_err();
    do_reset();
    clear_log();
    inj_d = 32'hDEAD_BEEF;
    inj_v = 1'b1;
    step();
    inj_v = 1'b0;
    tests_run++; if (err !== 1'b1) begin tests_failed++; $display("FAIL err_set: got %b want 1", err); end
    tests_run++; if (bus.o_rsp_tvalid !== 4'b0000) begin tests_failed++; $display("FAIL err_rsp_suppressed: got %b want 0000", bus.o_rsp_tvalid); end
    tests_run++; if (infl !== 4'd0) begin tests_failed++; $display("FAIL err_inflight: got %0d want 0", infl); end
    repeat (3) step();
    tests_run++; if (err !== 1'b1 || log_v.size() != 0) begin tests_failed++; $display("FAIL err_sticky: got err=%b rsps=%0d want 1/0", err, log_v.size()); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    clear_log();
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL mid_err_cleared: got %b want 0", err); end
    bus.i_req_tvalid = 4'b0001;
    repeat (5) step();
    tests_run++; if (infl !== 4'd5) begin tests_failed++; $display("FAIL mid_inflight: got %0d want 5", infl); end
`ifdef FLT_SCHED_PERF_CNT_EN
    tests_run++; if (issue_cnt[31:0] !== 32'd5) begin tests_failed++; $display("FAIL mid_cnt: got %0d want 5", issue_cnt[31:0]); end
`endif
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.o_req_tready !== 4'b0000 || bus.o_axi4s_a_tvalid !== 1'b0 || infl !== 4'd0 ||
        bus.o_rsp_tvalid !== 4'b0000 || err !== 1'b0 || drained !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs: got rdy=%b av=%b infl=%0d rsp=%b err=%b dr=%b want all 0",
               bus.o_req_tready, bus.o_axi4s_a_tvalid, infl, bus.o_rsp_tvalid, err, drained);
    end
    bus.i_req_tvalid = '0;
    step();
    step();
    rst = 1'b0;
    repeat (20) step();
    tests_run++; if (err !== 1'b1 || log_v.size() != 0) begin tests_failed++; $display("FAIL mid_late_results: got err=%b rsps=%0d want 1/0", err, log_v.size()); end
`ifdef FLT_SCHED_PERF_CNT_EN
    tests_run++; if (issue_cnt !== '0) begin tests_failed++; $display("FAIL mid_cnt_clear: got %h want 0", issue_cnt); end
`endif
  endtask

  initial begin
    bus.i_req_tvalid = '0;
    bus.i_req_tdata  = '0;
    test_reset();
    test_single();
    test_all4();
    test_two_sparse();
    test_drain();
    test_err();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
